// File: rtl/delay_bank_sched.sv
// Purpose : arbitrated, frame-sequenced z^-1 store; NSLOT requesters each own one
//           WIDTH-bit delay slot, served round-robin once per frame, all slots commit together.
// Latency : rdata is combinational with gnt; a written value is readable in the next frame.
//           Backpressure: req is held until gnt, one grant per cycle, at most one per slot per frame.
// Build option: DLY_ZERO_ON_MISS_EN -- slots missed in an overrun frame commit 0 instead of
//               keeping their previous value.
module delay_bank_sched #(
    parameter int WIDTH = 24,
    parameter int NSLOT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic [NSLOT-1:0]       req,
    input  logic [NSLOT*WIDTH-1:0] wdata,
    output logic [NSLOT-1:0]       gnt,
    output logic [WIDTH-1:0]       rdata,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    localparam int PW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [NSLOT-1:0][WIDTH-1:0]   active_q, active_d;
    logic [NSLOT-1:0][WIDTH-1:0]   shadow_q, shadow_d;
    logic [NSLOT-1:0]              served_q, served_d;
    logic [PW-1:0]                 rr_ptr_q, rr_ptr_d;
    logic                          pend_q, pend_d;
    logic                          overrun_q, overrun_d;

    logic [NSLOT-1:0]              eligible;
    logic                          gnt_any;
    logic [PW-1:0]                 gnt_idx;
    logic [PW-1:0]                 scan_idx;
    logic [NSLOT-1:0]              gnt_vec;

    // Round-robin pick: first eligible slot starting at rr_ptr, wrapping modulo NSLOT.
    always_comb begin
        eligible = req & ~served_q;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        gnt_vec  = '0;
        if (state_q == ST_COLLECT) begin
            for (int i = 0; i < NSLOT; i++) begin
                scan_idx = PW'((int'(rr_ptr_q) + i) % NSLOT);
                if (!gnt_any && eligible[scan_idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = scan_idx;
                end
            end
        end
        if (gnt_any) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    assign gnt     = gnt_vec;
    assign rdata   = gnt_any ? active_q[gnt_idx] : '0;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_COMMIT);
    assign overrun = overrun_q;

    // Frame sequencing: collect grants into shadow, then commit shadow to active in one cycle.
    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        served_d  = served_q;
        rr_ptr_d  = rr_ptr_q;
        pend_d    = pend_q;
        overrun_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d  = ST_COLLECT;
                    served_d = '0;
`ifdef DLY_ZERO_ON_MISS_EN
                    shadow_d = '0;
`else
                    shadow_d = active_q;
`endif
                end
            end
            ST_COLLECT: begin
                if (gnt_any) begin
                    shadow_d[gnt_idx] = wdata[int'(gnt_idx)*WIDTH +: WIDTH];
                    served_d          = served_q | gnt_vec;
                    rr_ptr_d          = PW'((int'(gnt_idx) + 1) % NSLOT);
                end
                if (&served_d) begin
                    // Final grant and a new frame_start together is a normal close, not an overrun.
                    state_d = ST_COMMIT;
                    if (frame_start) begin
                        pend_d = 1'b1;
                    end
                end else if (frame_start) begin
                    overrun_d = 1'b1;
                    pend_d    = 1'b1;
                    state_d   = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                active_d = shadow_q;
                served_d = '0;
                pend_d   = 1'b0;
                if (pend_q || frame_start) begin
                    state_d = ST_COLLECT;
                    // Shadow already equals the freshly committed state unless misses are flushed.
`ifdef DLY_ZERO_ON_MISS_EN
                    shadow_d = '0;
`else
                    shadow_d = shadow_q;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            active_q  <= '0;
            shadow_q  <= '0;
            served_q  <= '0;
            rr_ptr_q  <= '0;
            pend_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            served_q  <= served_d;
            rr_ptr_q  <= rr_ptr_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_delay_bank_sched.sv
// Purpose : self-checking bench for delay_bank_sched against a frame-level reference model.
// Latency : inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: requesters hold req until granted unless a scenario deliberately re-holds it.
module tb_delay_bank_sched;

    localparam int N  = 4;
    localparam int W  = 24;
    localparam int PW = 2;

    logic             clk;
    logic             reset;
    logic             frame_start;
    logic [N-1:0]     req;
    logic [N*W-1:0]   wdata;
    logic [N-1:0]     gnt;
    logic [W-1:0]     rdata;
    logic             busy;
    logic             done;
    logic             overrun;

    int nchk  = 0;
    int nfail = 0;

    // Reference model: frame state (0 idle, 1 collecting, 2 committing), set of served
    // slots, values written this frame, committed values, round-robin start.
    int           m_state = 0;
    logic [N-1:0] m_served = '0;
    int           m_rr = 0;
    bit           m_pend = 0;
    bit           m_ovr = 0;
    logic [W-1:0] m_act [N];
    logic [W-1:0] m_wr  [N];

    logic [N-1:0] o_gnt, e_gnt;
    logic [W-1:0] o_rdata, e_rdata;
    logic         o_busy, e_busy, o_done, e_done, o_ovr, e_ovr;

    int           gorder [16];
    logic [W-1:0] grd    [16];
    int           gcount;
    bit           saw_ovr;

    delay_bank_sched #(.WIDTH(W), .NSLOT(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .req         (req),
        .wdata       (wdata),
        .gnt         (gnt),
        .rdata       (rdata),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: drive inputs, predict and capture outputs, then advance the model.
    task automatic step(input logic fs, input logic [N-1:0] rq, input logic [N*W-1:0] wd,
                        input logic rst);
        int           k;
        bit           any;
        bit           nov;
        logic [N-1:0] elig;
        logic [PW-1:0] kk;
        frame_start = fs;
        req         = rq;
        wdata       = wd;
        reset       = rst;
        @(negedge clk);
        e_gnt   = '0;
        e_rdata = '0;
        any     = 0;
        k       = 0;
        if (m_state == 1) begin
            elig = rq & ~m_served;
            for (int i = 0; i < N; i++) begin
                if (!any && (((elig >> ((m_rr + i) % N)) & N'(1)) != '0)) begin
                    any = 1;
                    k   = (m_rr + i) % N;
                end
            end
        end
        kk = PW'(k);
        if (any) begin
            e_gnt   = N'(1) << k;
            e_rdata = m_act[kk];
        end
        e_busy  = (m_state != 0);
        e_done  = (m_state == 2);
        e_ovr   = m_ovr;
        o_gnt   = gnt;
        o_rdata = rdata;
        o_busy  = busy;
        o_done  = done;
        o_ovr   = overrun;
        @(posedge clk);
        nov = 0;
        if (!rst) begin
            m_state  = 0;
            m_served = '0;
            m_rr     = 0;
            m_pend   = 0;
            for (int j = 0; j < N; j++) begin
                m_act[j] = '0;
                m_wr[j]  = '0;
            end
        end else if (m_state == 0) begin
            if (fs) begin
                m_state  = 1;
                m_served = '0;
            end
        end else if (m_state == 1) begin
            if (any) begin
                m_wr[kk]  = wd[k*W +: W];
                m_served  = m_served | (N'(1) << k);
                m_rr      = (k + 1) % N;
            end
            if (m_served == {N{1'b1}}) begin
                m_state = 2;
                if (fs) m_pend = 1;
            end else if (fs) begin
                nov     = 1;
                m_pend  = 1;
                m_state = 2;
            end
        end else begin
            for (int j = 0; j < N; j++) begin
                if (m_served[j]) begin
                    m_act[j] = m_wr[j];
                end else begin
`ifdef DLY_ZERO_ON_MISS_EN
                    m_act[j] = '0;
`else
                    m_act[j] = m_act[j];
`endif
                end
            end
            m_state  = (m_pend || fs) ? 1 : 0;
            m_pend   = 0;
            m_served = '0;
        end
        m_ovr = nov;
        #1;
    endtask

    // Drive one frame to its commit, recording observed grant order and read data.
    task automatic do_frame(input logic [N-1:0] rq, input logic [W-1:0] base, input int fs_at,
                            input bit hold);
        logic [N-1:0]   pending;
        logic [N*W-1:0] wd;
        bit             fin;
        for (int k = 0; k < N; k++) wd[k*W +: W] = base | W'(k);
        gcount  = 0;
        saw_ovr = 0;
        pending = rq;
        if (m_state == 0) begin
            step(1'b1, '0, wd, 1'b1);
            nchk++;
            if ({o_gnt, o_rdata, o_busy, o_done, o_ovr} !== {e_gnt, e_rdata, e_busy, e_done, e_ovr}) begin
                nfail++;
                $display("FAIL frame_open gnt=%b/%b rdata=%h/%h busy=%b/%b done=%b/%b ovr=%b/%b",
                         o_gnt, e_gnt, o_rdata, e_rdata, o_busy, e_busy, o_done, e_done, o_ovr, e_ovr);
            end
        end
        fin = 0;
        for (int c = 0; c < 20 && !fin; c++) begin
            step(1'(c == fs_at), hold ? rq : pending, wd, 1'b1);
            nchk++;
            if ({o_gnt, o_rdata, o_busy, o_done, o_ovr} !== {e_gnt, e_rdata, e_busy, e_done, e_ovr}) begin
                nfail++;
                $display("FAIL frame_cycle c=%0d gnt=%b/%b rdata=%h/%h busy=%b/%b done=%b/%b ovr=%b/%b",
                         c, o_gnt, e_gnt, o_rdata, e_rdata, o_busy, e_busy, o_done, e_done, o_ovr, e_ovr);
            end
            for (int k = 0; k < N; k++) begin
                if (o_gnt[k] === 1'b1 && gcount < 16) begin
                    gorder[gcount] = k;
                    grd[gcount]    = o_rdata;
                    gcount++;
                end
            end
            pending = pending & ~e_gnt;
            if (o_done === 1'b1) begin
                fin     = 1;
                saw_ovr = (o_ovr === 1'b1);
            end
        end
        nchk++;
        if (!fin) begin
            nfail++;
            $display("FAIL frame_timeout done not seen within 20 cycles, required 1");
        end
    endtask

    task automatic test_reset();
        step(1'b0, '0, '0, 1'b0);
        step(1'b1, {N{1'b1}}, '1, 1'b0);
        nchk++;
        if ({o_gnt, o_rdata, o_busy, o_done, o_ovr} !== '0) begin
            nfail++;
            $display("FAIL reset_outputs gnt=%b rdata=%h busy=%b done=%b ovr=%b required all 0",
                     o_gnt, o_rdata, o_busy, o_done, o_ovr);
        end
    endtask

    task automatic test_basic();
        do_frame(4'b1111, 24'h000000, -1, 0);
        nchk++;
        if (gcount != 4 || gorder[0] != 0 || gorder[1] != 1 || gorder[2] != 2 || gorder[3] != 3) begin
            nfail++;
            $display("FAIL first_frame_order count=%0d order=%0d%0d%0d%0d required 4 0123",
                     gcount, gorder[0], gorder[1], gorder[2], gorder[3]);
        end
        nchk++;
        if (grd[0] !== 0 || grd[1] !== 0 || grd[2] !== 0 || grd[3] !== 0) begin
            nfail++;
            $display("FAIL first_frame_rdata %h %h %h %h required 0", grd[0], grd[1], grd[2], grd[3]);
        end
        do_frame(4'b1111, 24'hA00000, -1, 0);
        for (int k = 0; k < 4; k++) begin
            nchk++;
            if (grd[k] !== W'(k)) begin
                nfail++;
                $display("FAIL second_frame_rdata slot=%0d got %h required %h", k, grd[k], W'(k));
            end
        end
        do_frame(4'b1111, 24'hC00000, -1, 0);
        for (int k = 0; k < 4; k++) begin
            nchk++;
            if (grd[k] !== (24'hA00000 | W'(k))) begin
                nfail++;
                $display("FAIL third_frame_rdata slot=%0d got %h required %h", k, grd[k], 24'hA00000 | W'(k));
            end
        end
    endtask

    task automatic test_overrun_rr();
        logic [W-1:0] miss_val;
        do_frame(4'b0011, 24'hB00000, 5, 0);
        nchk++;
        if (gcount != 2 || saw_ovr != 1) begin
            nfail++;
            $display("FAIL overrun_flag grants=%0d ovr=%0d required 2 1", gcount, saw_ovr);
        end
        nchk++;
        if (o_busy !== 1'b1) begin
            nfail++;
            $display("FAIL overrun_busy got %b required 1", o_busy);
        end
        do_frame(4'b1111, 24'hD00000, -1, 0);
        nchk++;
        if (gcount != 4 || gorder[0] != 2 || gorder[1] != 3 || gorder[2] != 0 || gorder[3] != 1) begin
            nfail++;
            $display("FAIL rr_order order=%0d%0d%0d%0d required 2301",
                     gorder[0], gorder[1], gorder[2], gorder[3]);
        end
`ifdef DLY_ZERO_ON_MISS_EN
        miss_val = '0;
`else
        miss_val = 24'hC00002;
`endif
        nchk++;
        if (grd[0] !== miss_val || grd[1] !== (miss_val == 0 ? 24'h0 : 24'hC00003) ||
            grd[2] !== 24'hB00000 || grd[3] !== 24'hB00001) begin
            nfail++;
            $display("FAIL overrun_values got %h %h %h %h", grd[0], grd[1], grd[2], grd[3]);
        end
    endtask

    task automatic test_rehold();
        do_frame(4'b0001, 24'hE00000, 4, 1);
        nchk++;
        if (gcount != 1 || gorder[0] != 0) begin
            nfail++;
            $display("FAIL rehold_single grants=%0d first=%0d required 1 0", gcount, gorder[0]);
        end
        do_frame(4'b1111, 24'h100000, -1, 1);
        nchk++;
        if (gcount != 4 || gorder[3] != 0 || grd[3] !== 24'hE00000) begin
            nfail++;
            $display("FAIL rehold_next grants=%0d last=%0d rdata=%h required 4 0 e00000",
                     gcount, gorder[3], grd[3]);
        end
    endtask

    task automatic test_back_to_back();
        do_frame(4'b1111, 24'h200000, 3, 0);
        nchk++;
        if (saw_ovr != 0 || m_state != 1) begin
            nfail++;
            $display("FAIL final_grant_fs ovr=%0d required 0", saw_ovr);
        end
        step(1'b0, '0, '0, 1'b1);
        nchk++;
        if (o_busy !== 1'b1) begin
            nfail++;
            $display("FAIL pend_open busy got %b required 1", o_busy);
        end
        do_frame(4'b1111, 24'h300000, 4, 0);
        step(1'b0, '0, '0, 1'b1);
        nchk++;
        if (o_busy !== 1'b1) begin
            nfail++;
            $display("FAIL commit_fs busy got %b required 1", o_busy);
        end
        do_frame(4'b1111, 24'h400000, -1, 0);
        step(1'b0, '0, '0, 1'b1);
        nchk++;
        if (o_busy !== 1'b0) begin
            nfail++;
            $display("FAIL back_to_idle busy got %b required 0", o_busy);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, '0, '0, 1'b1);
        step(1'b0, 4'b1111, '1, 1'b1);
        step(1'b0, 4'b1110, '1, 1'b1);
        step(1'b0, 4'b1100, '1, 1'b0);
        step(1'b0, 4'b1100, '1, 1'b1);
        nchk++;
        if ({o_gnt, o_rdata, o_busy, o_done, o_ovr} !== '0) begin
            nfail++;
            $display("FAIL reset_mid_outputs gnt=%b rdata=%h busy=%b done=%b ovr=%b required all 0",
                     o_gnt, o_rdata, o_busy, o_done, o_ovr);
        end
        do_frame(4'b1111, 24'h500000, -1, 0);
        nchk++;
        if (grd[0] !== 0 || grd[1] !== 0 || grd[2] !== 0 || grd[3] !== 0) begin
            nfail++;
            $display("FAIL reset_mid_rdata %h %h %h %h required 0", grd[0], grd[1], grd[2], grd[3]);
        end
    endtask

    task automatic test_random();
        logic [N*W-1:0] wd;
        logic           fs;
        logic           rst;
        logic [N-1:0]   rq;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) wd[k*W +: W] = W'($urandom);
            fs  = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 199) != 0);
            rq  = N'($urandom);
            step(fs, rq, wd, rst);
            nchk++;
            if ({o_gnt, o_rdata, o_busy, o_done, o_ovr} !== {e_gnt, e_rdata, e_busy, e_done, e_ovr}) begin
                nfail++;
                $display("FAIL random c=%0d gnt=%b/%b rdata=%h/%h busy=%b/%b done=%b/%b ovr=%b/%b",
                         c, o_gnt, e_gnt, o_rdata, e_rdata, o_busy, e_busy, o_done, e_done, o_ovr, e_ovr);
            end
        end
    endtask

    initial begin
        for (int j = 0; j < N; j++) begin
            m_act[j] = '0;
            m_wr[j]  = '0;
        end
        reset       = 1'b0;
        frame_start = 1'b0;
        req         = '0;
        wdata       = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_overrun_rr();
        test_rehold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
